rf_dump: RTL and testbench

Sequential reader for the 8x16 register file. On a start pulse it walks a contiguous, wrapping range of registers through one RF read port and streams each value out over a valid/ready interface with backpressure. It is used for debug/context-save dumps and sits beside the RF, sharing one read-select mux input via the top-level arbitration.

---
 rtl/rf_dump_pkg.sv | 25 ++
 rtl/rf_dump_en_ff.sv | 24 ++
 rtl/rf_dump.sv | 110 +++++++++++
 tb/tb_rf_dump.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared RF geometry, dump FSM encoding and count clamp helper.
// Rev 1.0
`default_nettype none

package rf_dump_pkg;

   localparam int RF_NREG   = 8;
   localparam int RF_SEL_W  = 3;
   localparam int RF_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // A count of zero, or one larger than the register file, means "dump all".
   function automatic logic [3:0] clamp_count(input logic [3:0] c, input int nreg);
      return (c == 4'd0 || c > 4'(nreg)) ? 4'(nreg) : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rf_dump_en_ff.sv
// rf_dump_en_ff: enable flip-flop cell with synchronous active-low clear.
// Rev 1.0
`default_nettype none

module rf_dump_en_ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

`default_nettype wire

// File: rtl/rf_dump.sv
// rf_dump: walks a wrapping register range through one RF read port and streams it out.
// Rev 1.0
`default_nettype none

module rf_dump
   import rf_dump_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int NREG   = RF_NREG,
   parameter int SEL_W  = RF_SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SEL_W-1:0]  first_reg,
   input  logic [3:0]        count,
   output logic [SEL_W-1:0]  rf_rd_sel,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_regnum,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int HOLD_W = DATA_W + SEL_W + 1;

   state_t            state;
   state_t            state_nxt;
   logic [SEL_W-1:0]  cur;
   logic [3:0]        rem;
   logic              hs;
   logic              advance;
   logic              load_word;
   logic              last_d;
   logic [HOLD_W-1:0] hold_q;

   assign hs      = out_valid & out_ready;
   assign advance = (state == ST_SEND) & hs & ~out_last;

   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_SEND;
         ST_SEND: if (hs && out_last) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // On an accepted non-final word the next register is read in the same cycle,
   // which keeps out_valid high and sustains one word per cycle.
   always_comb begin
      rf_rd_sel = advance ? cur + SEL_W'(1) : cur;
      load_word = (state == ST_LOAD) | advance;
      last_d    = advance ? (rem == 4'd2) : (rem == 4'd1);
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur       <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= start & (state != ST_IDLE);
         if (state == ST_IDLE && start) begin
            cur <= first_reg;
            rem <= clamp_count(count, NREG);
         end else if (advance) begin
            cur <= cur + SEL_W'(1);
            rem <= rem - 4'd1;
         end
         if (state == ST_LOAD)
            out_valid <= 1'b1;
         else if (state == ST_SEND && hs && out_last)
            out_valid <= 1'b0;
      end
   end

   rf_dump_en_ff #(
      .WIDTH(HOLD_W)
   ) u_hold (
      .clk(clk),
      .rst(rst),
      .en (load_word),
      .d  ({rf_rd_data, rf_rd_sel, last_d}),
      .q  (hold_q)
   );

   assign out_data   = hold_q[HOLD_W-1 -: DATA_W];
   assign out_regnum = hold_q[SEL_W:1];
   assign out_last   = hold_q[0];

endmodule

`default_nettype wire

// File: tb/tb_rf_dump.sv
// tb_rf_dump: directed and randomized dumps checked against a word-list model of the RF.
// Rev 1.0
`default_nettype none

module tb_rf_dump;

   typedef struct packed {
      logic [2:0]  sel;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  first_reg;
   logic [3:0]  count;
   logic [2:0]  rf_rd_sel;
   logic [15:0] rf_rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_regnum;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        err;

   logic [15:0] rf [8];
   logic [15:0] rf_init [8];
   logic        load_all;
   logic        we;
   logic [2:0]  wa;
   logic [15:0] wd;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Behavioural RF: combinational read, write lands at the edge (no bypass).
   always @(posedge clk) begin
      if (load_all) begin
         for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
      end else if (we) begin
         rf[wa] <= wd;
      end
   end
   assign rf_rd_data = rf[rf_rd_sel];

   rf_dump dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .first_reg (first_reg),
      .count     (count),
      .rf_rd_sel (rf_rd_sel),
      .rf_rd_data(rf_rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_regnum(out_regnum),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic set_rf(input int mode);
      @(negedge clk);
      for (int i = 0; i < 8; i++)
         rf_init[i] = (mode == 0) ? 16'(16'h1000 + i) : 16'($urandom);
      load_all = 1'b1;
      @(negedge clk);
      load_all = 1'b0;
   endtask

   function automatic logic ready_for(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc < 2) ? 1'b1 : (((cyc - 2) % 3) == 0);
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected stream: the list of (regnum, value) pairs covered by the range.
   task automatic run_dump(input int f, input int c, input int mode, input int restart_cyc,
                           input int wr_cyc, input int wr_a, input logic [15:0] wr_d,
                           input int exp_done);
      exp_t q[$];
      exp_t e;
      int   n, cyc, last_hs;
      bit   fin;
      n = (c == 0 || c > 8) ? 8 : c;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         e.sel  = 3'((f + i) % 8);
         e.data = rf[(f + i) % 8];
         q.push_back(e);
      end
      start     = 1'b1;
      first_reg = 3'(f);
      count     = 4'(c);
      out_ready = ready_for(mode, 0);
      #1;
      chk("busy_at_start", {31'd0, busy}, 32'd0);
      last_hs = -1;
      fin     = 1'b0;
      cyc     = 0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_cyc);
         if (start) begin
            first_reg = 3'($urandom_range(0, 7));
            count     = 4'($urandom_range(1, 8));
         end
         we        = (cyc == wr_cyc);
         wa        = 3'(wr_a);
         wd        = wr_d;
         out_ready = ready_for(mode, cyc);
         #1;
         chk("err", {31'd0, err}, {31'd0, (cyc == restart_cyc + 1)});
         chk("busy", {31'd0, busy}, 32'd1);
         chk("valid", {31'd0, out_valid}, {31'd0, (cyc >= 2 && q.size() > 0)});
         if (out_valid && q.size() > 0) begin
            chk("data", {16'd0, out_data}, {16'd0, q[0].data});
            chk("regnum", {29'd0, out_regnum}, {29'd0, q[0].sel});
            chk("last", {31'd0, out_last}, {31'd0, (q.size() == 1)});
            if (out_ready) begin
               void'(q.pop_front());
               if (q.size() == 0) last_hs = cyc;
            end
         end
         chk("done", {31'd0, done}, {31'd0, (last_hs >= 0 && cyc == last_hs + 1)});
         if (done || cyc >= 300) fin = 1'b1;
      end
      if (exp_done >= 0) chk("done_latency", cyc, exp_done);
      chk("words_left", q.size(), 0);
      we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         chk("idle_busy", {31'd0, busy}, 32'd0);
         chk("idle_valid", {31'd0, out_valid}, 32'd0);
         chk("idle_done", {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      first_reg = '0;
      count     = '0;
      out_ready = 1'b0;
      load_all  = 1'b0;
      we        = 1'b0;
      wa        = '0;
      wd        = '0;
      for (int i = 0; i < 8; i++) rf_init[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {16'd0, out_data}, 32'd0);
      chk("rst_regnum", {29'd0, out_regnum}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_sel", {29'd0, rf_rd_sel}, 32'd0);
      rst = 1'b1;

      // Full dump, continuous ready, done lands 10 cycles after start.
      set_rf(0);
      run_dump(0, 0, 0, -1, -1, 0, 16'h0, 10);
      // Wrapping range 6,7,0,1.
      run_dump(6, 4, 0, -1, -1, 0, 16'h0, 6);
      // Backpressure pattern 1,0,0,1,...
      run_dump(2, 3, 1, -1, -1, 0, 16'h0, -1);
      // Second start during an active dump.
      run_dump(1, 5, 0, 2, -1, 0, 16'h0, 7);

      // Reset in the middle of SEND with a word pending.
      set_rf(1);
      @(negedge clk);
      start = 1'b1; first_reg = 3'd0; count = 4'd8; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_data", {16'd0, out_data}, 32'd0);
      chk("abort_sel", {29'd0, rf_rd_sel}, 32'd0);
      rst       = 1'b1;
      out_ready = 1'b1;
      rf_init[5] = 16'hBEEF;
      load_all = 1'b1;
      @(negedge clk);
      load_all = 1'b0;
      run_dump(5, 1, 0, -1, -1, 0, 16'h0, 3);

      // Write to r2 in its capture cycle returns the old value, then the new one.
      run_dump(2, 1, 0, -1, 1, 2, 16'hAAAA, 3);
      chk("r2_written", {16'd0, rf[2]}, 32'h0000AAAA);
      run_dump(2, 1, 0, -1, -1, 0, 16'h0, 3);

      // Randomized ranges, counts (including 0 and >8) and ready.
      for (int t = 0; t < 8; t++) begin
         set_rf(1);
         run_dump($urandom_range(0, 7), $urandom_range(0, 15), 2, -1, -1, 0, 16'h0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
